// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
// read_write encoding matches the requester's LDR/STR strobe.
package mem_resp_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic MEM_READ   = 1'b1;
  localparam logic MEM_WRITE  = 1'b0;
  localparam int   ADDR_W_DEF = 16;
  localparam int   DATA_W_DEF = 32;
  localparam int   CNT_W      = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory control stage (master) and the responder (slave).
// One request outstanding at a time; resp_valid is a single-cycle completion pulse.
interface data_mem_responder_if #(
  parameter int ADDR_W = mem_resp_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_resp_pkg::DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp_valid;
  logic              resp_error;

  modport master (
    output req_valid, read_write, address, wdata,
    input  req_ready, rdata, resp_valid, resp_error
  );

  modport slave (
    input  req_valid, read_write, address, wdata,
    output req_ready, rdata, resp_valid, resp_error
  );
endinterface

// File: rtl/mem_word_array.sv
// DEPTH x DATA_W word storage: synchronous write, registered read.
// dout only changes on a read strobe, so it holds the last word read.
module mem_word_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
    if (re) dout_q <= mem_q[addr];
  end

  assign dout = dout_q;
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_CYCLES, commits the access on RESP entry,
// and pulses resp_valid for one cycle (accept at edge N -> response after edge N+WAIT_CYCLES+1).
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_responder_if.slave bus
);
  localparam int               AW      = $clog2(DEPTH);
  localparam logic [1:0]       S_IDLE  = IDLE;
  localparam logic [1:0]       S_WAIT  = WAIT;
  localparam logic [1:0]       S_RESP  = RESP;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rzero_q, rzero_d;
  logic              in_range;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_dout;

  assign in_range = (32'(addr_q) < 32'(DEPTH));

  // WAIT is always entered and left when the counter is zero, so WAIT_CYCLES=0 still
  // costs one edge and the latency is uniformly WAIT_CYCLES+1 edges after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rzero_d = rzero_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LD;
          addr_d  = bus.address;
          rw_d    = bus.read_write;
          wdata_d = bus.wdata;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          err_d   = !in_range;
          if (rw_q == MEM_READ) begin
            mem_re  = in_range;
            rzero_d = !in_range;
          end else begin
            mem_we  = (rw_q == MEM_WRITE) && in_range;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= MEM_READ;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rzero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rzero_q <= rzero_d;
    end
  end

  mem_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q[AW-1:0]),
    .din  (wdata_q),
    .dout (mem_dout)
  );

  // Array output is unreset; rzero_q masks it to 0 after reset and out-of-range reads.
  assign bus.rdata      = rzero_q ? '0 : mem_dout;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_error = (state_q == S_RESP) && err_q;
endmodule
